// File: rtl/explosion_pkg.sv
// Shared definitions for the explosion sprite pipeline.
//   expl_state_t : sequencer state encoding
//   SCREEN_W/H   : visible raster size
//   COORD_W      : width of every pixel coordinate bus
package explosion_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARMED = 2'd1,
      PLAY  = 2'd2
   } expl_state_t;

   localparam int SCREEN_W = 640;
   localparam int SCREEN_H = 480;
   localparam int COORD_W  = 10;

endpackage

// File: rtl/explosion_sequencer_window.sv
// sprite_window: combinational hit test of the current raster pixel against
// a square sprite placed at (i_pos_x, i_pos_y).
//   i_draw_x/y : current pixel
//   i_pos_x/y  : sprite top-left corner
//   i_en       : sprite active
//   o_inside   : pixel lies inside the active sprite
//   o_addr     : sprite-local address {rel_y, rel_x}, 0 when outside
module sprite_window
   import explosion_pkg::*;
#(
   parameter int SPRITE_SIZE = 32
) (
   input  logic [COORD_W-1:0]                   i_draw_x,
   input  logic [COORD_W-1:0]                   i_draw_y,
   input  logic [COORD_W-1:0]                   i_pos_x,
   input  logic [COORD_W-1:0]                   i_pos_y,
   input  logic                                 i_en,
   output logic                                 o_inside,
   output logic [2*$clog2(SPRITE_SIZE)-1:0]     o_addr
);

   localparam int AW = $clog2(SPRITE_SIZE);

   logic signed [COORD_W:0] w_rel_x;
   logic signed [COORD_W:0] w_rel_y;
   logic                    w_in_x;
   logic                    w_in_y;

   assign w_rel_x = $signed({1'b0, i_draw_x}) - $signed({1'b0, i_pos_x});
   assign w_rel_y = $signed({1'b0, i_draw_y}) - $signed({1'b0, i_pos_y});

   // All bits from AW upward being zero means 0 <= rel < SPRITE_SIZE; a
   // negative value has the sign bit set, so it can never pass.
   assign w_in_x = (w_rel_x[COORD_W:AW] == '0);
   assign w_in_y = (w_rel_y[COORD_W:AW] == '0);

   assign o_inside = i_en && w_in_x && w_in_y;
   assign o_addr   = o_inside ? {w_rel_y[AW-1:0], w_rel_x[AW-1:0]} : '0;

endmodule

// File: rtl/explosion_sequencer.sv
// explosion_sequencer: accepts a hit event, waits for a frame boundary, then
// steps the explosion animation one stage every FRAMES_PER_STAGE frames and
// produces registered per-pixel sprite coverage and ROM address.
//   vga_clk, reset_n       : pixel clock, async active-low reset
//   frame_tick             : start-of-vblank pulse
//   hit, hit_x, hit_y      : explosion request and sprite top-left position
//   DrawX, DrawY           : current raster pixel
//   busy, stage, done      : sequencing status
//   sprite_on, rom_address : pixel path, one cycle behind DrawX/DrawY
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | no explosion; waiting for hit
// ARMED | position captured; waiting for the next frame boundary
// PLAY  | animation running, stage advances on frame ticks
module explosion_sequencer
   import explosion_pkg::*;
#(
   parameter int SPRITE_SIZE      = 32,
   parameter int NUM_STAGES       = 3,
   parameter int FRAMES_PER_STAGE = 6
) (
   input  logic                               vga_clk,
   input  logic                               reset_n,
   input  logic                               frame_tick,
   input  logic                               hit,
   input  logic [COORD_W-1:0]                 hit_x,
   input  logic [COORD_W-1:0]                 hit_y,
   input  logic [COORD_W-1:0]                 DrawX,
   input  logic [COORD_W-1:0]                 DrawY,
   output logic                               busy,
   output logic [1:0]                         stage,
   output logic                               sprite_on,
   output logic [2*$clog2(SPRITE_SIZE)-1:0]   rom_address,
   output logic                               done
);

   localparam int AW   = 2*$clog2(SPRITE_SIZE);
   localparam int FC_W = (FRAMES_PER_STAGE > 1) ? $clog2(FRAMES_PER_STAGE) : 1;
   localparam logic [FC_W-1:0] FRAME_LAST = FC_W'(FRAMES_PER_STAGE-1);
   localparam logic [1:0]      STAGE_LAST = 2'(NUM_STAGES-1);

   expl_state_t          r_state;
   logic [COORD_W-1:0]   r_pend_x;
   logic [COORD_W-1:0]   r_pend_y;
   logic [COORD_W-1:0]   r_pos_x;
   logic [COORD_W-1:0]   r_pos_y;
   logic [1:0]           r_stage;
   logic [FC_W-1:0]      r_frame_cnt;
   logic                 r_done;
   logic                 r_sprite_on;
   logic [AW-1:0]        r_rom_address;

   logic                 w_inside;
   logic [AW-1:0]        w_addr;

   // Frame timer is a down-counter: loaded with FRAME_LAST, the stage
   // advances on the tick that finds it at zero.
   always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= IDLE;
         r_pend_x    <= '0;
         r_pend_y    <= '0;
         r_pos_x     <= '0;
         r_pos_y     <= '0;
         r_stage     <= '0;
         r_frame_cnt <= '0;
         r_done      <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (hit) begin
                  r_pend_x <= hit_x;
                  r_pend_y <= hit_y;
                  r_state  <= ARMED;
               end
            end
            ARMED: begin
               if (frame_tick) begin
                  r_pos_x     <= r_pend_x;
                  r_pos_y     <= r_pend_y;
                  r_stage     <= '0;
                  r_frame_cnt <= FRAME_LAST;
                  r_state     <= PLAY;
               end
            end
            PLAY: begin
               if (frame_tick) begin
                  if (r_frame_cnt == '0) begin
                     r_frame_cnt <= FRAME_LAST;
                     if (r_stage == STAGE_LAST) begin
                        r_stage <= '0;
                        r_done  <= 1'b1;
                        r_state <= IDLE;
                     end else begin
                        r_stage <= r_stage + 2'd1;
                     end
                  end else begin
                     r_frame_cnt <= r_frame_cnt - 1'b1;
                  end
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   sprite_window #(
      .SPRITE_SIZE (SPRITE_SIZE)
   ) u_window (
      .i_draw_x (DrawX),
      .i_draw_y (DrawY),
      .i_pos_x  (r_pos_x),
      .i_pos_y  (r_pos_y),
      .i_en     (r_state == PLAY),
      .o_inside (w_inside),
      .o_addr   (w_addr)
   );

   // One register stage lines the pixel path up with the synchronous ROM.
   always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) begin
         r_sprite_on   <= 1'b0;
         r_rom_address <= '0;
      end else begin
         r_sprite_on   <= w_inside;
         r_rom_address <= w_addr;
      end
   end

   // State is registered, so busy rises the cycle after the hit is taken
   // and drops on the same edge that raises done.
   assign busy        = (r_state != IDLE);
   assign stage       = r_stage;
   assign done        = r_done;
   assign sprite_on   = r_sprite_on;
   assign rom_address = r_rom_address;

endmodule
